mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the combinational alu in the EX stage.
- Executes mult/multu/div/divu over multiple cycles, and mfhi/mflo/mthi/mtlo in one cycle.
- Takes the same instruction/regA/regB/result/flags interface style as the alu, plus a valid/ready handshake so the pipeline stalls while busy.

Parameters:
- XLEN, 32: operand, result, HI and LO width; any even value >= 8.
- CNT_W, $clog2(XLEN)+1: iteration counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- instruction  in  32  decoded by opcode [31:26] and funct [5:0].
- regA  in  XLEN  rs operand; dividend / multiplicand.
- regB  in  XLEN  rt operand; divisor / multiplier.
- in_valid  in  1  instruction and operands valid this cycle.
- in_ready  out  1  unit can accept.
- result  out  XLEN  LO for mult/div; HI/LO for mfhi/mflo; written value for mthi/mtlo.
- flags  out  3  [2] zero, [1] negative, [0] divide-by-zero.
- out_valid  out  1  one-cycle pulse; result/flags valid.
- busy  out  1  iterative operation in flight.

Behaviour:
- Reset (synchronous, active-high): state IDLE, HI=LO=0, result=0, flags=000, out_valid=0, busy=0, in_ready=1. Reset mid-operation aborts with no out_valid and HI/LO cleared.
- Accept rule: in_ready = (state==IDLE). An instruction is accepted on a clk edge where in_valid && in_ready. Operands are sampled only on accept. in_valid held while busy is not accepted until in_ready returns.
- Decode (opcode 0x00): funct 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu. Anything else is accepted, ignored, and gives no out_valid.
- States: IDLE -> MUL | DIV -> FIX -> DONE -> IDLE.
  - IDLE handles mf*/mt* directly: result, and HI/LO for mt*, are registered with out_valid=1 on the next cycle (latency 1).
  - mult/div: load magnitudes, record signs (signed ops only), count=XLEN.
  - MUL: radix-2 shift-add, one bit per cycle.
  - DIV: restoring divide, one quotient bit per cycle.
  - FIX: negate the 2XLEN product if signs differ; negate quotient if signs differ; remainder takes the dividend's sign.
  - DONE: write HI/LO, result=LO, out_valid=1 for one cycle.
- Iterative latency: out_valid is asserted XLEN+2 cycles after the accept edge (34 for XLEN=32). busy=1 from accept until DONE inclusive.
- Divide by zero (regB==0, div or divu): IDLE -> DONE directly (latency 1). HI=regA, LO=all ones, flags[0]=1.
- Signed MIN / -1: LO=MIN, HI=0, flags[0]=0 (two's-complement wrap, no trap).
- Flags:
  - zero = (mult: full 2XLEN product==0; otherwise result==0).
  - negative = result[XLEN-1].
  - All flags are 000 for mt*.
- No new accept occurs in the DONE cycle; back-to-back throughput is XLEN+3 cycles.

Optional Feature:
- MDU_MADD_EN defined: adds opcode 0x1C funct 0x00 madd (signed) and 0x01 maddu (unsigned). They follow the mult path, then in DONE {HI,LO} <= {HI,LO} + product, modulo 2^(2XLEN), with the same latency. Flags are computed on the new {HI,LO}.
- MDU_MADD_EN undefined: opcode 0x1C is treated as unrecognised (accepted, ignored).

Decomposition:
- Package mdu_pkg:
  - opcode/funct localparams (FUNCT_MFHI, FUNCT_MULT, OP_SPECIAL2, ...).
  - state enum encoding.
  - flag bit indices FLAG_ZERO=2, FLAG_NEG=1, FLAG_DBZ=0.
- One sub-module, mdu_div_core: restoring divide datapath (remainder/quotient shift registers and trial subtract), stepped by the parent FSM. The multiply datapath stays in the parent.

Test Plan (XLEN=32):
- mult regA=0xFFFFFFFF, regB=0x00000002 -> out_valid exactly 34 cycles after accept, result=0xFFFFFFFE, flags=010. A following mfhi gives 0xFFFFFFFF after 1 cycle.
- multu with the same operands -> LO=0xFFFFFFFE, HI=0x00000001. div regA=-7 (0xFFFFFFF9), regB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1.
- divu regA=5, regB=0 -> out_valid 1 cycle after accept, LO=0xFFFFFFFF, HI=5, flags=011.
- div regA=0x80000000, regB=0xFFFFFFFF -> LO=0x80000000, HI=0, flags=010. mtlo 0 then mflo -> result 0, flags=100.
- in_valid held with mflo during a mult -> in_ready=0 and no accept for 34 cycles; mflo then returns the new LO. Reset asserted at cycle 10 of a mult -> no out_valid, in_ready=1 next cycle, mfhi=0.
- MDU_MADD_EN defined: mthi 0, mtlo 5, madd 3*4 -> LO=17, HI=0. MDU_MADD_EN undefined: same sequence leaves LO=5 with no out_valid for the madd.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcode and funct
// codes, FSM state encoding, flag bit positions and a flag packing helper.
// The optional madd/maddu codes are only decoded when MDU_MADD_EN is defined.
package mdu_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_MADD  = 6'h00;
    localparam logic [5:0] FUNCT_MADDU = 6'h01;

    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_DBZ  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mdu_state_t;

    function automatic logic [2:0] make_flags(input logic zero, input logic neg, input logic dbz);
        logic [2:0] f;
        f            = '0;
        f[FLAG_ZERO] = zero;
        f[FLAG_NEG]  = neg;
        f[FLAG_DBZ]  = dbz;
        return f;
    endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Instruction/operand/result bundle between the EX stage and the multiply/
// divide unit. The pipeline side is the master; the unit is the slave.
interface mdu_iterative_if #(parameter int XLEN = 32);

    logic [31:0]     instruction;
    logic [XLEN-1:0] regA;
    logic [XLEN-1:0] regB;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] result;
    logic [2:0]      flags;
    logic            out_valid;
    logic            busy;

    modport master (
        output instruction, regA, regB, in_valid,
        input  in_ready, result, flags, out_valid, busy
    );

    modport slave (
        input  instruction, regA, regB, in_valid,
        output in_ready, result, flags, out_valid, busy
    );

endinterface

// File: rtl/mdu_div_core.sv
// Restoring divider datapath working on operand magnitudes. The parent FSM
// loads it once and then steps it XLEN times; each step shifts one dividend
// bit into the partial remainder and produces one quotient bit.
module mdu_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    // Trial subtraction of the divisor from the shifted partial remainder;
    // a set top bit means the subtraction went negative and is discarded.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, dvs_q};
    end

    // Remainder/quotient shift registers, advanced one bit per step.
    always_ff @(posedge clk) begin
        if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            if (!trial[XLEN]) begin
                rem_q <= trial[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// mult/multu/div/divu run for XLEN+2 cycles; mfhi/mflo/mthi/mtlo answer in
// one cycle. Defining MDU_MADD_EN adds madd/maddu, which accumulate the
// product into {HI,LO}.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic          clk,
    input  logic          rst,
    mdu_iterative_if.slave bus
);

    mdu_state_t        state_q, state_d;
    logic [XLEN-1:0]   hi_q, lo_q, result_q, mcand_q;
    logic [2:0]        flags_q;
    logic              out_valid_q;
    logic [2*XLEN-1:0] prod_q, prod_fix, mul_total;
    logic [CNT_W-1:0]  count_q;
    logic              is_div_q, neg_res_q, neg_rem_q;
`ifdef MDU_MADD_EN
    logic              is_madd_q;
`endif

    logic [5:0]        opcode, funct;
    logic              is_special, accept, div_by_zero, op_signed;
    logic              op_mfhi, op_mthi, op_mflo, op_mtlo, op_mul, op_div, op_madd;
    logic [XLEN-1:0]   mag_a, mag_b, mul_addend, div_quo, div_rem, quo_fix, rem_fix;
    logic [XLEN:0]     mul_sum;
    logic              div_load, div_step;
    logic              unused_instr_bits;

    assign unused_instr_bits = ^bus.instruction[25:6];

    // Instruction decode and operand magnitudes for the signed variants.
    always_comb begin
        opcode      = bus.instruction[31:26];
        funct       = bus.instruction[5:0];
        is_special  = (opcode == OP_SPECIAL);
        accept      = bus.in_valid && (state_q == ST_IDLE);
        op_mfhi     = is_special && (funct == FUNCT_MFHI);
        op_mthi     = is_special && (funct == FUNCT_MTHI);
        op_mflo     = is_special && (funct == FUNCT_MFLO);
        op_mtlo     = is_special && (funct == FUNCT_MTLO);
        op_madd     = 1'b0;
`ifdef MDU_MADD_EN
        op_madd     = (opcode == OP_SPECIAL2) && ((funct == FUNCT_MADD) || (funct == FUNCT_MADDU));
`endif
        op_mul      = (is_special && ((funct == FUNCT_MULT) || (funct == FUNCT_MULTU))) || op_madd;
        op_div      = is_special && ((funct == FUNCT_DIV) || (funct == FUNCT_DIVU));
        op_signed   = (is_special && ((funct == FUNCT_MULT) || (funct == FUNCT_DIV)))
                    || (op_madd && (funct == FUNCT_MADD));
        div_by_zero = (bus.regB == '0);
        mag_a       = (op_signed && bus.regA[XLEN-1]) ? -bus.regA : bus.regA;
        mag_b       = (op_signed && bus.regB[XLEN-1]) ? -bus.regB : bus.regB;
    end

    // Next-state logic; also tells the divider when to load and when to step.
    always_comb begin
        state_d  = state_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && op_mul) begin
                    state_d = ST_MUL;
                end else if (accept && op_div) begin
                    if (div_by_zero) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_DIV;
                        div_load = 1'b1;
                    end
                end
            end
            ST_MUL:  if (count_q == CNT_W'(1)) state_d = ST_FIX;
            ST_DIV: begin
                div_step = 1'b1;
                if (count_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Shift-add step, sign correction and (optionally) accumulation into HI/LO.
    always_comb begin
        mul_addend = prod_q[0] ? mcand_q : '0;
        mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        prod_fix   = neg_res_q ? -prod_q : prod_q;
        mul_total  = prod_fix;
`ifdef MDU_MADD_EN
        if (is_madd_q) mul_total = {hi_q, lo_q} + prod_fix;
`endif
        quo_fix    = neg_res_q ? -div_quo : div_quo;
        rem_fix    = neg_rem_q ? -div_rem : div_rem;
    end

    // Datapath: single-cycle HI/LO moves, multiply iterations, and the HI/LO
    // write on the edge leaving FIX so that DONE presents the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            prod_q      <= '0;
            mcand_q     <= '0;
            count_q     <= '0;
            is_div_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`ifdef MDU_MADD_EN
            is_madd_q   <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (op_mfhi) begin
                            result_q    <= hi_q;
                            flags_q     <= make_flags(hi_q == '0, hi_q[XLEN-1], 1'b0);
                            out_valid_q <= 1'b1;
                        end else if (op_mflo) begin
                            result_q    <= lo_q;
                            flags_q     <= make_flags(lo_q == '0, lo_q[XLEN-1], 1'b0);
                            out_valid_q <= 1'b1;
                        end else if (op_mthi) begin
                            hi_q        <= bus.regA;
                            result_q    <= bus.regA;
                            flags_q     <= '0;
                            out_valid_q <= 1'b1;
                        end else if (op_mtlo) begin
                            lo_q        <= bus.regA;
                            result_q    <= bus.regA;
                            flags_q     <= '0;
                            out_valid_q <= 1'b1;
                        end else if (op_mul) begin
                            prod_q    <= {{XLEN{1'b0}}, mag_b};
                            mcand_q   <= mag_a;
                            count_q   <= CNT_W'(XLEN);
                            is_div_q  <= 1'b0;
                            neg_res_q <= op_signed && (bus.regA[XLEN-1] ^ bus.regB[XLEN-1]);
`ifdef MDU_MADD_EN
                            is_madd_q <= op_madd;
`endif
                        end else if (op_div) begin
                            if (div_by_zero) begin
                                hi_q        <= bus.regA;
                                lo_q        <= '1;
                                result_q    <= '1;
                                flags_q     <= make_flags(1'b0, 1'b1, 1'b1);
                                out_valid_q <= 1'b1;
                            end else begin
                                count_q   <= CNT_W'(XLEN);
                                is_div_q  <= 1'b1;
                                neg_res_q <= op_signed && (bus.regA[XLEN-1] ^ bus.regB[XLEN-1]);
                                neg_rem_q <= op_signed && bus.regA[XLEN-1];
                            end
                        end
                    end
                end
                ST_MUL: begin
                    prod_q  <= {mul_sum, prod_q[XLEN-1:1]};
                    count_q <= count_q - CNT_W'(1);
                end
                ST_DIV: count_q <= count_q - CNT_W'(1);
                ST_FIX: begin
                    out_valid_q <= 1'b1;
                    if (is_div_q) begin
                        lo_q     <= quo_fix;
                        hi_q     <= rem_fix;
                        result_q <= quo_fix;
                        flags_q  <= make_flags(quo_fix == '0, quo_fix[XLEN-1], 1'b0);
                    end else begin
                        {hi_q, lo_q} <= mul_total;
                        result_q     <= mul_total[XLEN-1:0];
                        flags_q      <= make_flags(mul_total == '0, mul_total[XLEN-1], 1'b0);
                    end
                end
                default: ;
            endcase
        end
    end

    mdu_div_core #(.XLEN(XLEN)) u_div_core (
        .clk       (clk),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative (XLEN=32). Directed instructions push
// their hand-computed result, flags and latency into a queue on accept; an
// independent monitor pops and compares on every out_valid. The madd vectors
// follow MDU_MADD_EN so the same bench covers both builds.
module tb_mdu_iterative;
    import mdu_pkg::*;

    localparam int XLEN   = 32;
    localparam int PERIOD = 10;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic [2:0]  flags;
        int          latency;
        longint      accept_time;
    } expect_t;

    logic    clk;
    logic    rst;
    expect_t exp_q[$];
    int      compared   = 0;
    int      mismatched = 0;
    int      waited;

    mdu_iterative_if #(.XLEN(XLEN)) bus();

    mdu_iterative #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    function automatic logic [31:0] sp(input logic [5:0] f);
        return {OP_SPECIAL, 20'h0, f};
    endfunction

    function automatic logic [31:0] sp2(input logic [5:0] f);
        return {OP_SPECIAL2, 20'h0, f};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Holds in_valid until the unit accepts, then queues the expected response.
    task automatic applyStimulus(input string name, input logic [31:0] instr,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit expect_out, input logic [31:0] exp_result,
                                 input logic [2:0] exp_flags, input int exp_latency,
                                 output int wait_cycles);
        expect_t e;
        @(negedge clk);
        bus.instruction = instr;
        bus.regA        = a;
        bus.regB        = b;
        bus.in_valid    = 1'b1;
        wait_cycles     = 0;
        while (!bus.in_ready && wait_cycles < 200) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (!bus.in_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_accept: got no accept after %0d cycles, required accept", name, wait_cycles);
        end else begin
            @(posedge clk);
            if (expect_out) begin
                e.name        = name;
                e.result      = exp_result;
                e.flags       = exp_flags;
                e.latency     = exp_latency;
                e.accept_time = longint'($time);
                exp_q.push_back(e);
            end
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Monitor: every out_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        expect_t e;
        longint  dt;
        int      lat;
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_out_valid: got result 0x%08h flags %03b, required no output",
                         bus.result, bus.flags);
            end else begin
                e   = exp_q.pop_front();
                dt  = longint'($time) - e.accept_time;
                lat = int'((dt - PERIOD/2) / PERIOD) + 1;
                checkOutput({e.name, "_result"}, bus.result, e.result);
                checkOutput({e.name, "_flags"}, 32'(bus.flags), 32'(e.flags));
                checkOutput({e.name, "_latency"}, lat, e.latency);
            end
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #(PERIOD * 20000);
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus.
    initial begin
        rst             = 1'b1;
        bus.instruction = '0;
        bus.regA        = '0;
        bus.regB        = '0;
        bus.in_valid    = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        checkOutput("reset_flags", 32'(bus.flags), 32'd0);
        rst = 1'b0;

        applyStimulus("mult_m1x2", sp(FUNCT_MULT), 32'hFFFFFFFF, 32'h2, 1, 32'hFFFFFFFE, 3'b010, 34, waited);
        checkOutput("busy_during_mult", 32'(bus.busy), 32'd1);
        checkOutput("in_ready_during_mult", 32'(bus.in_ready), 32'd0);
        applyStimulus("mfhi_after_mult", sp(FUNCT_MFHI), 0, 0, 1, 32'hFFFFFFFF, 3'b010, 1, waited);

        applyStimulus("multu_m1x2", sp(FUNCT_MULTU), 32'hFFFFFFFF, 32'h2, 1, 32'hFFFFFFFE, 3'b010, 34, waited);
        applyStimulus("mfhi_after_multu", sp(FUNCT_MFHI), 0, 0, 1, 32'h1, 3'b000, 1, waited);

        applyStimulus("div_m7_2", sp(FUNCT_DIV), 32'hFFFFFFF9, 32'h2, 1, 32'hFFFFFFFD, 3'b010, 34, waited);
        applyStimulus("mfhi_after_div", sp(FUNCT_MFHI), 0, 0, 1, 32'hFFFFFFFF, 3'b010, 1, waited);

        applyStimulus("div_7_m2", sp(FUNCT_DIV), 32'h7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 3'b010, 34, waited);
        applyStimulus("mfhi_after_div_7_m2", sp(FUNCT_MFHI), 0, 0, 1, 32'h1, 3'b000, 1, waited);

        applyStimulus("divu_7_2", sp(FUNCT_DIVU), 32'h7, 32'h2, 1, 32'h3, 3'b000, 34, waited);
        applyStimulus("mfhi_after_divu", sp(FUNCT_MFHI), 0, 0, 1, 32'h1, 3'b000, 1, waited);

        applyStimulus("divu_by_zero", sp(FUNCT_DIVU), 32'h5, 32'h0, 1, 32'hFFFFFFFF, 3'b011, 1, waited);
        applyStimulus("mfhi_after_dbz", sp(FUNCT_MFHI), 0, 0, 1, 32'h5, 3'b000, 1, waited);

        applyStimulus("div_min_m1", sp(FUNCT_DIV), 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 3'b010, 34, waited);
        applyStimulus("mfhi_after_min_m1", sp(FUNCT_MFHI), 0, 0, 1, 32'h0, 3'b100, 1, waited);

        applyStimulus("mtlo_zero", sp(FUNCT_MTLO), 32'h0, 0, 1, 32'h0, 3'b000, 1, waited);
        applyStimulus("mflo_zero", sp(FUNCT_MFLO), 0, 0, 1, 32'h0, 3'b100, 1, waited);

        applyStimulus("mult_zero", sp(FUNCT_MULT), 32'h0, 32'h5, 1, 32'h0, 3'b100, 34, waited);
        applyStimulus("multu_2pow32", sp(FUNCT_MULTU), 32'h10000, 32'h10000, 1, 32'h0, 3'b000, 34, waited);
        applyStimulus("mfhi_2pow32", sp(FUNCT_MFHI), 0, 0, 1, 32'h1, 3'b000, 1, waited);

        applyStimulus("mult_3x5", sp(FUNCT_MULT), 32'h3, 32'h5, 1, 32'hF, 3'b000, 34, waited);
        applyStimulus("mflo_held", sp(FUNCT_MFLO), 0, 0, 1, 32'hF, 3'b000, 1, waited);
        checkOutput("held_wait_cycles", waited, 32'd34);

        applyStimulus("mthi_0", sp(FUNCT_MTHI), 32'h0, 0, 1, 32'h0, 3'b000, 1, waited);
        applyStimulus("mtlo_5", sp(FUNCT_MTLO), 32'h5, 0, 1, 32'h5, 3'b000, 1, waited);
`ifdef MDU_MADD_EN
        applyStimulus("madd_3x4", sp2(FUNCT_MADD), 32'h3, 32'h4, 1, 32'h11, 3'b000, 34, waited);
        applyStimulus("mflo_after_madd", sp(FUNCT_MFLO), 0, 0, 1, 32'h11, 3'b000, 1, waited);
`else
        applyStimulus("madd_3x4", sp2(FUNCT_MADD), 32'h3, 32'h4, 0, 32'h0, 3'b000, 0, waited);
        applyStimulus("mflo_after_madd", sp(FUNCT_MFLO), 0, 0, 1, 32'h5, 3'b000, 1, waited);
`endif
        applyStimulus("mfhi_after_madd", sp(FUNCT_MFHI), 0, 0, 1, 32'h0, 3'b100, 1, waited);
        applyStimulus("unknown_funct", sp(6'h20), 32'h1, 32'h2, 0, 32'h0, 3'b000, 0, waited);

        applyStimulus("mult_abort", sp(FUNCT_MULT), 32'h3, 32'h5, 0, 32'h0, 3'b000, 0, waited);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        applyStimulus("mfhi_after_abort", sp(FUNCT_MFHI), 0, 0, 1, 32'h0, 3'b100, 1, waited);
        applyStimulus("mflo_after_abort", sp(FUNCT_MFLO), 0, 0, 1, 32'h0, 3'b100, 1, waited);

        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
